tone_detector: RTL and testbench

- Receive-side counterpart to the tone generators. Measures the period of an incoming square-wave tone (tone_in) in system clock cycles and classifies it against the 8-note C4..C5 table.
- Reports a lock once the same note has been seen on consecutive periods.
- Used to check and monitor note playback, e.g. a loopback of the buzzer drive, in the song player.

---
 rtl/tone_detector.sv | 164 ++++++++++++++++
 tb/tb_tone_detector.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tone_detector.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tone_detector: measures tone_in period, classifies it to C4..C5, locks.  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tone_detector #(
   parameter int CLK_FREQ = 100_000_000,
   parameter int TOL      = 2000,
   parameter int TIMEOUT  = 500_000,
   parameter int STABLE   = 4,
   // Nominal periods in clk cycles: C4 in bits [18:0], C5 in the top slice
   parameter logic [8*19-1:0] NOTE_TABLE = {19'd191_113, 19'd202_478, 19'd227_273, 19'd255_102,
                                            19'd286_344, 19'd303_370, 19'd340_530, 19'd382_219}
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        tone_in,
   output logic [18:0] period,
   output logic        period_valid,
   output logic [2:0]  note_idx,
   output logic        note_hit,
   output logic        note_lock
);

   localparam logic [18:0] c_tol          = 19'(TOL);
   localparam logic [18:0] c_timeout_last = 19'(TIMEOUT - 1);
   localparam logic [3:0]  c_stable       = 4'(STABLE);

   generate
      if (TIMEOUT < 2 || TIMEOUT >= (1 << 19) || STABLE < 1 || STABLE > 15 ||
          TOL < 0 || CLK_FREQ <= 0) begin : g_bad_params
         $error("tone_detector: parameter out of range");
      end
   endgenerate

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      MEAS = 1'b1
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic        r_s1, r_s2, r_s3;
   logic [18:0] r_cnt;
   logic [18:0] w_cnt_nxt;
   logic [3:0]  r_stable;
   logic [3:0]  w_stable_nxt;
   logic        w_edge;
   logic        w_measured;
   logic        w_timeout;
   logic        w_hit;
   logic [2:0]  w_idx;
   logic [18:0] w_nom;
   logic [18:0] w_diff;

   assign w_edge = r_s2 & ~r_s3;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_measured  = 1'b0;
      w_timeout   = 1'b0;
      if (!en) begin
         w_state_nxt = IDLE;
         w_cnt_nxt   = '0;
      end else begin
         case (r_state)
            IDLE: begin
               w_cnt_nxt = '0;
               if (w_edge) begin
                  w_state_nxt = MEAS;
                  w_cnt_nxt   = 19'd1;
               end
            end
            MEAS: begin
               // An edge on the last count wins over the timeout
               if (w_edge) begin
                  w_measured = 1'b1;
                  w_cnt_nxt  = 19'd1;
               end else if (r_cnt == c_timeout_last) begin
                  w_timeout   = 1'b1;
                  w_state_nxt = IDLE;
                  w_cnt_nxt   = '0;
               end else begin
                  w_cnt_nxt = r_cnt + 19'd1;
               end
            end
            default: begin
               w_state_nxt = IDLE;
               w_cnt_nxt   = '0;
            end
         endcase
      end
   end

   // Scan from the top entry down so the lowest matching index wins
   always_comb begin
      w_hit  = 1'b0;
      w_idx  = 3'd0;
      w_nom  = '0;
      w_diff = '0;
      for (int k = 7; k >= 0; k--) begin
         w_nom  = NOTE_TABLE[k*19 +: 19];
         w_diff = (r_cnt >= w_nom) ? (r_cnt - w_nom) : (w_nom - r_cnt);
         if (w_diff <= c_tol) begin
            w_hit = 1'b1;
            w_idx = 3'(k);
         end
      end
   end

   always_comb begin
      if (!w_hit) begin
         w_stable_nxt = '0;
      end else if (note_hit && (w_idx == note_idx)) begin
         w_stable_nxt = (r_stable == c_stable) ? r_stable : (r_stable + 4'd1);
      end else begin
         w_stable_nxt = 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1         <= 1'b0;
         r_s2         <= 1'b0;
         r_s3         <= 1'b0;
         r_stable     <= '0;
         period       <= '0;
         period_valid <= 1'b0;
         note_idx     <= '0;
         note_hit     <= 1'b0;
         note_lock    <= 1'b0;
      end else begin
         r_s1         <= tone_in;
         r_s2         <= r_s1;
         r_s3         <= r_s2;
         period_valid <= w_measured;
         if (w_measured) begin
            period    <= r_cnt;
            note_idx  <= w_idx;
            note_hit  <= w_hit;
            r_stable  <= w_stable_nxt;
            note_lock <= (w_stable_nxt == c_stable);
         end else if (!en || w_timeout) begin
            note_hit  <= 1'b0;
            note_lock <= 1'b0;
            r_stable  <= '0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_tone_detector.sv
`default_nettype none
// Testbench for tone_detector on a scaled note table: table vectors, directed
// lock/timeout/interrupt sequences, and random tones against a reference model.
module tb_tone_detector;

   localparam int TOL     = 6;
   localparam int TIMEOUT = 500;
   localparam int STABLE  = 4;
   localparam int NOM [0:7] = '{382, 341, 303, 286, 255, 227, 202, 191};

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic        tone_in;
   logic [18:0] period;
   logic        period_valid;
   logic [2:0]  note_idx;
   logic        note_hit;
   logic        note_lock;

   int checks = 0;
   int errors = 0;

   tone_detector #(
      .CLK_FREQ   (100_000_000),
      .TOL        (TOL),
      .TIMEOUT    (TIMEOUT),
      .STABLE     (STABLE),
      .NOTE_TABLE ({19'd191, 19'd202, 19'd227, 19'd255, 19'd286, 19'd303, 19'd341, 19'd382})
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .tone_in      (tone_in),
      .period       (period),
      .period_valid (period_valid),
      .note_idx     (note_idx),
      .note_hit     (note_hit),
      .note_lock    (note_lock)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
         if (errors >= 200) begin
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
         end
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic tone_period(input int p);
      tone_in = 1'b1;
      tick(p / 2);
      tone_in = 1'b0;
      tick(p - p / 2);
   endtask

   task automatic quiet_restart();
      en      = 1'b0;
      tone_in = 1'b0;
      tick(4);
      en = 1'b1;
      tick(1);
   endtask

   // Every period_valid pulse is captured for the directed checks
   typedef struct {
      int per;
      int idx;
      bit hit;
      bit lock;
   } vrec_t;
   vrec_t vq[$];

   always @(negedge clk) begin
      if (period_valid === 1'b1)
         vq.push_back('{int'(period), int'(note_idx), note_hit, note_lock});
   end

   // Reference model: rising edges seen through a 3-sample delay line,
   // periods as timestamp differences, lock as a run length of equal notes.
   bit     mon_on = 1'b0;
   bit     hist[$] = '{1'b0, 1'b0, 1'b0};
   longint cyc    = 0;
   longint m_last = 0;
   bit     m_meas = 1'b0, m_valid = 1'b0, m_hit = 1'b0, m_lock = 1'b0;
   int     m_period = 0, m_idx = 0, m_run = 0;

   function automatic void classify(input int p, output bit hit, output int idx);
      int d;
      hit = 1'b0;
      idx = 0;
      for (int k = 0; k < 8; k++) begin
         d = (p > NOM[k]) ? (p - NOM[k]) : (NOM[k] - p);
         if (!hit && d <= TOL) begin
            hit = 1'b1;
            idx = k;
         end
      end
   endfunction

   always @(posedge clk) begin : ref_model
      bit e;
      bit h;
      int i;
      int p;
      cyc++;
      if (rst) begin
         hist     = '{1'b0, 1'b0, 1'b0};
         m_meas   = 1'b0;
         m_valid  = 1'b0;
         m_period = 0;
         m_idx    = 0;
         m_hit    = 1'b0;
         m_lock   = 1'b0;
         m_run    = 0;
      end else begin
         e = hist[1] && !hist[2];
         hist.push_front(tone_in);
         void'(hist.pop_back());
         m_valid = 1'b0;
         if (!en) begin
            m_meas = 1'b0;
            m_hit  = 1'b0;
            m_lock = 1'b0;
            m_run  = 0;
         end else if (e) begin
            if (m_meas) begin
               p = int'(cyc - m_last);
               classify(p, h, i);
               if (!h)                          m_run = 0;
               else if (m_hit && i == m_idx)    m_run++;
               else                             m_run = 1;
               m_period = p;
               m_idx    = i;
               m_hit    = h;
               m_lock   = (m_run >= STABLE);
               m_valid  = 1'b1;
            end
            m_meas = 1'b1;
            m_last = cyc;
         end else if (m_meas && (cyc + 1 - m_last) >= TIMEOUT) begin
            // The next cycle lies TIMEOUT cycles after the last edge: silent
            m_meas = 1'b0;
            m_hit  = 1'b0;
            m_lock = 1'b0;
            m_run  = 0;
         end
      end
   end

   always @(negedge clk) begin
      if (mon_on)
         chk("model_cycle {period,valid,idx,hit,lock}",
             {period, period_valid, note_idx, note_hit, note_lock},
             {19'(m_period), m_valid, 3'(m_idx), m_hit, m_lock});
   end

   typedef struct {
      int per;
      int idx;
      bit hit;
   } vec_t;

   task automatic lock_interrupt(input bit use_rst);
      string tag;
      tag = use_rst ? "rst" : "en";
      quiet_restart();
      repeat (5) tone_period(226);
      tone_in = 1'b1;
      tick(113);
      tone_in = 1'b0;
      tick(40);
      chk({tag, "_prelock"}, note_lock, 1);
      if (use_rst) rst = 1'b1;
      else         en  = 1'b0;
      tick(1);
      chk({tag, "_lock_cleared"}, note_lock, 0);
      chk({tag, "_hit_cleared"}, note_hit, 0);
      chk({tag, "_no_valid"}, period_valid, 0);
      if (use_rst) begin
         chk("rst_period_zero", period, 0);
         chk("rst_idx_zero", note_idx, 0);
      end else begin
         chk("en_period_holds", period, 226);
         chk("en_idx_holds", note_idx, 5);
      end
      rst = 1'b0;
      en  = 1'b1;
      tick(72);
      vq.delete();
      repeat (2) tone_period(226);
      tone_in = 1'b1;
      tick(8);
      tone_in = 1'b0;
      tick(2);
      chk({tag, "_resume_count"}, vq.size(), 2);
      if (vq.size() >= 1) begin
         chk({tag, "_resume_period"}, vq[0].per, 226);
         chk({tag, "_resume_idx"}, vq[0].idx, 5);
         chk({tag, "_resume_hit"}, vq[0].hit, 1);
         chk({tag, "_resume_lock"}, vq[0].lock, 0);
      end
   endtask

   initial begin
      vec_t tbl [14];
      int   k, off, reps;
      tbl = '{'{226, 5, 1'b1}, '{191, 7, 1'b1}, '{202, 6, 1'b1}, '{233, 5, 1'b1},
              '{221, 5, 1'b1}, '{234, 0, 1'b0}, '{220, 0, 1'b0}, '{196, 6, 1'b1},
              '{382, 0, 1'b1}, '{347, 1, 1'b1}, '{290, 3, 1'b1}, '{260, 4, 1'b1},
              '{310, 0, 1'b0}, '{184, 0, 1'b0}};

      rst     = 1'b1;
      en      = 1'b0;
      tone_in = 1'b0;
      tick(3);
      mon_on = 1'b1;
      chk("reset_period", period, 0);
      chk("reset_valid", period_valid, 0);
      chk("reset_idx", note_idx, 0);
      chk("reset_hit", note_hit, 0);
      chk("reset_lock", note_lock, 0);
      rst = 1'b0;
      en  = 1'b1;
      tick(4);

      // One isolated period per vector
      foreach (tbl[i]) begin
         quiet_restart();
         vq.delete();
         tone_period(tbl[i].per);
         tone_in = 1'b1;
         tick(6);
         chk($sformatf("tbl%0d_count", i), vq.size(), 1);
         if (vq.size() >= 1) begin
            chk($sformatf("tbl%0d_period", i), vq[0].per, tbl[i].per);
            chk($sformatf("tbl%0d_idx", i), vq[0].idx, tbl[i].idx);
            chk($sformatf("tbl%0d_hit", i), vq[0].hit, tbl[i].hit);
         end
      end

      // C5 three times then B4: note change restarts the run, no lock
      quiet_restart();
      vq.delete();
      repeat (3) tone_period(191);
      repeat (2) tone_period(202);
      tone_in = 1'b1;
      tick(8);
      chk("c5b4_count", vq.size(), 5);
      for (int i = 0; i < vq.size() && i < 5; i++) begin
         chk($sformatf("c5b4_idx%0d", i), vq[i].idx, (i < 3) ? 7 : 6);
         chk($sformatf("c5b4_lock%0d", i), vq[i].lock, 0);
      end

      // A4 lock, off-table drop, relock, then silence until timeout
      quiet_restart();
      vq.delete();
      repeat (6) tone_period(226);
      tone_period(220);
      repeat (5) tone_period(226);
      tone_in = 1'b1;
      tick(113);
      tone_in = 1'b0;
      tick(TIMEOUT + 1 - 113);
      chk("lock_before_timeout", note_lock, 1);
      tick(1);
      chk("lock_at_timeout", note_lock, 0);
      chk("hit_at_timeout", note_hit, 0);
      chk("period_holds_timeout", period, 226);
      chk("chain_valid_count", vq.size(), 12);
      for (int i = 0; i < vq.size() && i < 12; i++) begin
         chk($sformatf("chain_period%0d", i), vq[i].per, (i == 6) ? 220 : 226);
         chk($sformatf("chain_hit%0d", i), vq[i].hit, (i != 6));
         chk($sformatf("chain_idx%0d", i), vq[i].idx, (i == 6) ? 0 : 5);
         chk($sformatf("chain_lock%0d", i), vq[i].lock, (i < 6) ? (i >= 3) : (i >= 10));
      end
      tone_in = 1'b1;
      tick(20);
      chk("restart_no_valid", vq.size(), 12);
      tone_in = 1'b0;
      tick(4);

      lock_interrupt(1'b1);
      lock_interrupt(1'b0);

      // Random tones near the table with occasional enable drops
      quiet_restart();
      for (int n = 0; n < 30; n++) begin
         k    = int'($urandom_range(7, 0));
         off  = int'($urandom_range(20, 0)) - 10;
         reps = int'($urandom_range(4, 1));
         repeat (reps) tone_period(NOM[k] + off);
         if ($urandom_range(7, 0) == 0) begin
            en = 1'b0;
            tick(int'($urandom_range(3, 1)));
            en = 1'b1;
         end
      end

      tone_in = 1'b0;
      tick(5);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
